// File: rtl/pending_encoder8to3.sv
// pending_encoder8to3: sticky 8-line request capture with priority-encoded valid/ready output
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_i        request pulses, one bit per line, posted into the pending register
//   out_ready_i  consumer accepts the output slot when out_valid_o is also high
//   out_valid_o  out_idx_o holds an encoded event
//   out_idx_o    index of the granted line, highest pending index first
//   pending_o    pending lines, excluding the one held in the output slot
//   drop_cnt_o   saturating count of coalesced requests (PENDING_ENCODER_DROP_CNT_EN only)
//
// Optional feature macro: PENDING_ENCODER_DROP_CNT_EN
module pending_encoder8to3 #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [N-1:0]     pending_o
`ifdef PENDING_ENCODER_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt_o
`endif
);
  logic [N-1:0]     pend_q, pend_d, cand;
  logic             valid_q, valid_d, slot_free;
  logic [IDX_W-1:0] idx_q, idx_d, pick;
  always_comb begin
    cand      = pend_q | req_i;
    slot_free = !valid_q || out_ready_i;
    pick      = '0;
    // ascending scan: the highest set bit is the last to win
    for (int i = 0; i < N; i++)
      if (cand[i]) pick = IDX_W'(i);
    // an empty cand gives pick 0, so clearing bit 0 still yields zero
    pend_d  = slot_free ? cand & ~(N'(1) << pick) : cand;
    valid_d = slot_free ? |cand : valid_q;
    idx_d   = (slot_free && |cand) ? pick : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;
  assign pending_o   = pend_q;
`ifdef PENDING_ENCODER_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;
  // a request whose line is already pending is lost; the slot's own line is not pending
  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'($countones(req_i & pend_q));
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  assign drop_cnt_o = drop_q;
`endif
endmodule

// File: tb/tb_pending_encoder8to3.sv
// tb_pending_encoder8to3: randomized and directed checks against a behavioural model
module tb_pending_encoder8to3;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] req_i = 0;
  logic       out_ready_i = 0;
  logic       out_valid_o;
  logic [2:0] out_idx_o;
  logic [7:0] pending_o;
  int n_tests = 0;
  int n_fail  = 0;
`ifdef PENDING_ENCODER_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  pending_encoder8to3 dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o), .out_idx_o(out_idx_o), .pending_o(pending_o)
`ifdef PENDING_ENCODER_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // model: set of pending lines, one output slot, a lost-event tally
  bit m_pend [8];
  bit m_valid;
  int m_idx, m_drop;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_pend_val();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) v += 1 << i;
    return v;
  endfunction

  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_valid = 0; m_idx = 0; m_drop = 0;
  endtask

  task automatic m_edge();
    bit c [8];
    int top = -1;
    for (int i = 0; i < 8; i++) begin
      if (req_i[i] && m_pend[i]) m_drop++;
      c[i] = m_pend[i] || req_i[i];
    end
    if (m_drop > 255) m_drop = 255;
    if (m_valid && !out_ready_i) begin
      m_pend = c;
      return;
    end
    for (int i = 7; i >= 0 && top < 0; i--) if (c[i]) top = i;
    m_pend = c;
    if (top >= 0) begin
      m_pend[top] = 0; m_valid = 1; m_idx = top;
    end else m_valid = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, int'(out_valid_o), int'(m_valid));
    chk({tag, ".idx"}, int'(out_idx_o), m_idx);
    chk({tag, ".pend"}, int'(pending_o), m_pend_val());
`ifdef PENDING_ENCODER_DROP_CNT_EN
    chk({tag, ".drop"}, int'(drop_cnt_o), m_drop);
`endif
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_drain();
    req_i = 0; out_ready_i = 1;
    for (int i = 0; i < 12; i++) cyc("drain");
  endtask

  initial begin
    int cnt4, d0;
    m_reset();
    // reset held with all lines requesting
    rst_n = 0; req_i = 8'hFF; out_ready_i = 1;
    #1;
    chk("rst.valid", int'(out_valid_o), 0);
    chk("rst.idx", int'(out_idx_o), 0);
    chk("rst.pend", int'(pending_o), 0);
    cyc("rst_hold"); cyc("rst_hold");
    rst_n = 1;
    cyc("rst_rel");
    chk("rel.valid", int'(out_valid_o), 1);
    chk("rel.idx", int'(out_idx_o), 7);
    chk("rel.pend", int'(pending_o), 8'h7F);
    idle_drain();

    // drain order 7,5,2,0
    req_i = 8'hA5; out_ready_i = 1;
    cyc("drain_a5"); chk("order0", int'(out_idx_o), 7);
    req_i = 0;
    cyc("drain_a5"); chk("order1", int'(out_idx_o), 5);
    cyc("drain_a5"); chk("order2", int'(out_idx_o), 2);
    cyc("drain_a5"); chk("order3", int'(out_idx_o), 0);
    cyc("drain_a5");
    chk("order_end.valid", int'(out_valid_o), 0);
    chk("order_end.pend", int'(pending_o), 0);

    // backpressure
    out_ready_i = 0; req_i = 8'h02;
    cyc("bp"); req_i = 0;
    for (int i = 0; i < 10; i++) begin
      cyc("bp_hold"); chk("bp_held_idx", int'(out_idx_o), 1);
    end
    req_i = 8'h80; cyc("bp_post"); req_i = 0;
    chk("bp_pend80", int'(pending_o), 8'h80);
    chk("bp_idx_stays", int'(out_idx_o), 1);
    out_ready_i = 1; cyc("bp_release");
    chk("bp_next7", int'(out_idx_o), 7);
    idle_drain();

    // coalesce: slot holds line 0, line 4 posted three times
    out_ready_i = 0; req_i = 8'h01; cyc("co_slot"); req_i = 0;
`ifdef PENDING_ENCODER_DROP_CNT_EN
    d0 = int'(drop_cnt_o);
`else
    d0 = 0;
`endif
    for (int k = 0; k < 3; k++) begin
      req_i = 8'h10; cyc("co_pulse"); req_i = 0; cyc("co_gap");
    end
    chk("co_pend", int'(pending_o), 8'h10);
`ifdef PENDING_ENCODER_DROP_CNT_EN
    chk("co_drop", int'(drop_cnt_o) - d0, 2);
`endif
    out_ready_i = 1; cnt4 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc("co_drain");
      if (out_valid_o && out_idx_o == 3'd4) cnt4++;
    end
    chk("co_once", cnt4, 1);
    idle_drain();

    // same-line re-post on the accept edge
    out_ready_i = 0; req_i = 8'h08; cyc("rp_load"); req_i = 0;
    chk("rp_slot3", int'(out_idx_o), 3);
    cyc("rp_hold");
    out_ready_i = 1; req_i = 8'h08; cyc("rp_accept"); req_i = 0;
    chk("rp_again.valid", int'(out_valid_o), 1);
    chk("rp_again.idx", int'(out_idx_o), 3);
    cyc("rp_after");
    chk("rp_after.valid", int'(out_valid_o), 0);

    // async reset between edges
    out_ready_i = 0; req_i = 8'h1C; cyc("ar_load"); req_i = 0;
    chk("ar_pre.valid", int'(out_valid_o), 1);
    chk("ar_pre.pend", int'(pending_o), 8'h0C);
    #2 rst_n = 0; m_reset();
    #1;
    chk("ar.valid", int'(out_valid_o), 0);
    chk("ar.idx", int'(out_idx_o), 0);
    chk("ar.pend", int'(pending_o), 0);
`ifdef PENDING_ENCODER_DROP_CNT_EN
    chk("ar.drop", int'(drop_cnt_o), 0);
`endif
    cyc("ar_hold");
    rst_n = 1;

    // random traffic: sparse pulses, random ready
    for (int i = 0; i < 1500; i++) begin
      req_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      out_ready_i = ($urandom_range(0, 2) != 0);
      cyc("rnd");
    end
    // heavy traffic under stall, enough to saturate the drop counter
    for (int i = 0; i < 150; i++) begin
      req_i = 8'($urandom);
      out_ready_i = ($urandom_range(0, 9) == 0);
      cyc("rnd_heavy");
    end
    idle_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
